pipemem_stage: RTL and testbench

Memory-access stage of the five-stage pipelined CPU, sitting between the EX/MEM register outputs and the register-file write-back path. It consumes the M-stage control and data bundle and runs a registered request/acknowledge transaction with the data memory for loads and stores. It stalls the upstream pipeline while a transaction is outstanding, then registers the MEM/WB bundle. A watchdog bounds every transaction.

---
 rtl/pipemem_stage_pkg.sv | 19 +
 rtl/pipemwreg.sv | 42 ++++
 rtl/pipemem_stage.sv | 150 +++++++++++++++
 tb/tb_pipemem_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipemem_stage_pkg.sv
// Shared CPU definitions for the memory-access stage: FSM encoding, bundle widths,
// default watchdog limit and a saturating counter helper.
package pipemem_stage_pkg;

    localparam int unsigned DataWidth      = 32;
    localparam int unsigned RegWidth       = 5;
    localparam int unsigned CntWidth       = 8;
    localparam int unsigned DefaultTimeout = 15;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == {CntWidth{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipemwreg.sv
// MEM/WB pipeline register; a bubble loads all-zero control and data.
module pipemwreg
    import pipemem_stage_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 bubble,
    input  logic                 mwreg,
    input  logic                 mm2reg,
    input  logic [DataWidth-1:0] mmo,
    input  logic [DataWidth-1:0] malu,
    input  logic [RegWidth-1:0]  mrn,
    output logic                 wwreg,
    output logic                 wm2reg,
    output logic [DataWidth-1:0] wmo,
    output logic [DataWidth-1:0] walu,
    output logic [RegWidth-1:0]  wrn
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= '0;
            walu   <= '0;
            wrn    <= '0;
        end else if (bubble) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= '0;
            walu   <= '0;
            wrn    <= '0;
        end else begin
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
            wmo    <= mmo;
            walu   <= malu;
            wrn    <= mrn;
        end
    end

endmodule

// File: rtl/pipemem_stage.sv
// Memory-access stage: registered req/ack transaction with the data memory, upstream stall,
// watchdog-forced completion with a sticky error flag, and the MEM/WB register.
module pipemem_stage
    import pipemem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 mwreg,
    input  logic                 mm2reg,
    input  logic                 mwmem,
    input  logic [DataWidth-1:0] malu,
    input  logic [DataWidth-1:0] mb,
    input  logic [RegWidth-1:0]  mrn,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DataWidth-1:0] dmem_addr,
    output logic [DataWidth-1:0] dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DataWidth-1:0] dmem_rdata,
    output logic                 mstall,
    output logic                 merr,
    output logic                 wwreg,
    output logic                 wm2reg,
    output logic [DataWidth-1:0] wmo,
    output logic [DataWidth-1:0] walu,
    output logic [RegWidth-1:0]  wrn
);

    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  merr_q, merr_d;
    logic                  we_q;
    logic [DataWidth-1:0]  addr_q, wdata_q;

    logic                  memop;
    logic                  issue;
    logic                  stall;
    logic                  bubble;
    logic                  wb_wreg;
    logic                  wb_m2reg;
    logic [DataWidth-1:0]  wb_mo;
    logic [DataWidth-1:0]  wb_alu;
    logic [RegWidth-1:0]   wb_rn;

    assign memop = mm2reg | mwmem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        merr_d   = merr_q;
        issue    = 1'b0;
        stall    = 1'b0;
        bubble   = 1'b1;
        wb_wreg  = mwreg;
        wb_m2reg = mm2reg;
        wb_mo    = '0;
        wb_alu   = malu;
        wb_rn    = mrn;

        unique case (state_q)
            StIdle: begin
                // dmem_ack is deliberately not looked at here
                if (memop) begin
                    stall   = 1'b1;
                    issue   = 1'b1;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    bubble = 1'b0;
                end
            end
            StWait: begin
                if (dmem_ack) begin
                    bubble  = 1'b0;
                    wb_mo   = mwmem ? '0 : dmem_rdata;
                    req_d   = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    // Forced completion: retire without a register write
                    bubble  = 1'b0;
                    wb_wreg = 1'b0;
                    merr_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    cnt_d = sat_inc(cnt_q);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            merr_q  <= merr_d;
        end
    end

    // Request attributes are captured once at issue and held through WAIT
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (issue) begin
            we_q    <= mwmem;
            addr_q  <= malu;
            wdata_q <= mb;
        end
    end

    pipemwreg u_pipemwreg (
        .clock  (clock),
        .resetn (resetn),
        .bubble (bubble),
        .mwreg  (wb_wreg),
        .mm2reg (wb_m2reg),
        .mmo    (wb_mo),
        .malu   (wb_alu),
        .mrn    (wb_rn),
        .wwreg  (wwreg),
        .wm2reg (wm2reg),
        .wmo    (wmo),
        .walu   (walu),
        .wrn    (wrn)
    );

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mstall     = stall;
    assign merr       = merr_q;

endmodule

// File: tb/tb_pipemem_stage.sv
// Directed bench for pipemem_stage: ALU pass-through, load, store, watchdog and reset cases.
module tb_pipemem_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mstall, merr, wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pipemem_stage #(.TIMEOUT(15)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .malu       (malu),
        .mb         (mb),
        .mrn        (mrn),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .mstall     (mstall),
        .merr       (merr),
        .wwreg      (wwreg),
        .wm2reg     (wm2reg),
        .wmo        (wmo),
        .walu       (walu),
        .wrn        (wrn)
    );

    task automatic drive(input logic wr, input logic ld, input logic st, input logic [31:0] alu,
                         input logic [31:0] b, input logic [4:0] rn);
        mwreg  = wr;
        mm2reg = ld;
        mwmem  = st;
        malu   = alu;
        mb     = b;
        mrn    = rn;
    endtask

    task automatic edge_sample();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        #12;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== 66'h0) begin
            errors++;
            $display("FAIL reset_dmem: got %h expected 0", {dmem_req, dmem_we, dmem_addr, dmem_wdata});
        end
        checks++;
        if ({mstall, merr, wwreg, wm2reg, wmo, walu, wrn} !== 73'h0) begin
            errors++;
            $display("FAIL reset_wb: got %h expected 0", {mstall, merr, wwreg, wm2reg, wmo, walu, wrn});
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // ALU op with a spurious ack in IDLE
    task automatic test_alu();
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd5);
        dmem_ack = 1'b1;
        #1;
        checks++;
        if (mstall !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: got %b expected 0", mstall);
        end
        edge_sample();
        checks++;
        if ({wwreg, wm2reg, walu, wrn, wmo} !== {1'b1, 1'b0, 32'h10, 5'd5, 32'h0}) begin
            errors++;
            $display("FAIL alu_wb: got %b %b %h %0d %h expected 1 0 10 5 0",
                     wwreg, wm2reg, walu, wrn, wmo);
        end
        checks++;
        if ({dmem_req, merr} !== 2'b00) begin
            errors++;
            $display("FAIL alu_spurious_ack: req/merr got %b%b expected 00", dmem_req, merr);
        end
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_load();
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3);
        #1;
        checks++;
        if (mstall !== 1'b1) begin
            errors++;
            $display("FAIL load_issue_stall: got %b expected 1", mstall);
        end
        edge_sample();
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, wwreg} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
            errors++;
            $display("FAIL load_req: req=%b we=%b addr=%h wwreg=%b expected 1 0 40 0",
                     dmem_req, dmem_we, dmem_addr, wwreg);
        end
        @(negedge clock);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (mstall !== 1'b0) begin
            errors++;
            $display("FAIL load_ack_stall: got %b expected 0", mstall);
        end
        edge_sample();
        checks++;
        if ({wwreg, wm2reg, wmo, walu, wrn} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 32'h40, 5'd3}) begin
            errors++;
            $display("FAIL load_wb: got %b %b %h %h %0d expected 1 1 deadbeef 40 3",
                     wwreg, wm2reg, wmo, walu, wrn);
        end
        checks++;
        if ({dmem_req, dmem_we} !== 2'b00) begin
            errors++;
            $display("FAIL load_done_req: req/we got %b%b expected 00", dmem_req, dmem_we);
        end
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_store();
        int stalls = 0;
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b1, 32'h80, 32'h1234, 5'd0);
        #1;
        if (mstall === 1'b1) stalls++;
        edge_sample();
        for (int w = 1; w <= 4; w++) begin
            @(negedge clock);
            #1;
            if (mstall === 1'b1) stalls++;
            checks++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg} !==
                {1'b1, 1'b1, 32'h80, 32'h1234, 1'b0}) begin
                errors++;
                $display("FAIL store_hold_w%0d: req=%b we=%b addr=%h wdata=%h wwreg=%b", w,
                         dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg);
            end
            edge_sample();
        end
        @(negedge clock);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        #1;
        if (mstall === 1'b1) stalls++;
        edge_sample();
        checks++;
        if (stalls !== 5) begin
            errors++;
            $display("FAIL store_stall_cycles: got %0d expected 5", stalls);
        end
        checks++;
        if ({wwreg, wm2reg, wmo, dmem_req} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL store_wb: wwreg=%b wm2reg=%b wmo=%h req=%b expected 0 0 0 0",
                     wwreg, wm2reg, wmo, dmem_req);
        end
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // Ack arrives on the very cycle the watchdog would fire
    task automatic test_ack_at_timeout();
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd12);
        edge_sample();
        for (int w = 1; w <= 15; w++) begin
            @(negedge clock);
            if (w == 15) begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'h0000_CAFE;
            end
            edge_sample();
        end
        checks++;
        if ({merr, wwreg, wmo, wrn} !== {1'b0, 1'b1, 32'h0000_CAFE, 5'd12}) begin
            errors++;
            $display("FAIL ack_at_timeout: merr=%b wwreg=%b wmo=%h wrn=%0d expected 0 1 cafe 12",
                     merr, wwreg, wmo, wrn);
        end
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_timeout();
        logic exp_stall;
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7);
        edge_sample();
        for (int w = 1; w <= 15; w++) begin
            @(negedge clock);
            #1;
            exp_stall = (w < 15);
            if (w >= 14) begin
                checks++;
                if (mstall !== exp_stall) begin
                    errors++;
                    $display("FAIL timeout_stall_w%0d: got %b expected %b", w, mstall, exp_stall);
                end
            end
            edge_sample();
        end
        checks++;
        if ({merr, wwreg, wmo, dmem_req} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_forced: merr=%b wwreg=%b wmo=%h req=%b expected 1 0 0 0",
                     merr, wwreg, wmo, dmem_req);
        end
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 5'd9);
        #1;
        checks++;
        if (mstall !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next_stall: got %b expected 0", mstall);
        end
        edge_sample();
        checks++;
        if ({wwreg, walu, wrn, merr} !== {1'b1, 32'h55, 5'd9, 1'b1}) begin
            errors++;
            $display("FAIL timeout_next_alu: wwreg=%b walu=%h wrn=%0d merr=%b expected 1 55 9 1",
                     wwreg, walu, wrn, merr);
        end
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        edge_sample();
        checks++;
        if (merr !== 1'b1) begin
            errors++;
            $display("FAIL merr_sticky: got %b expected 1", merr);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd4);
        edge_sample();
        edge_sample();
        @(negedge clock);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL midwait_pre_req: got %b expected 1", dmem_req);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, merr} !== 67'h0) begin
            errors++;
            $display("FAIL midwait_reset_dmem: got %h expected 0",
                     {dmem_req, dmem_we, dmem_addr, dmem_wdata, merr});
        end
        checks++;
        if ({wwreg, wm2reg, wmo, walu, wrn} !== 71'h0) begin
            errors++;
            $display("FAIL midwait_reset_wb: got %h expected 0", {wwreg, wm2reg, wmo, walu, wrn});
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clock);
        resetn     = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        edge_sample();
        checks++;
        if ({wwreg, wm2reg, wmo, dmem_req, mstall} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midwait_no_wb: wwreg=%b wm2reg=%b wmo=%h req=%b stall=%b expected 0",
                     wwreg, wm2reg, wmo, dmem_req, mstall);
        end
        @(negedge clock);
        dmem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
